// File: rtl/bus_bridge_hs.sv
// CPU-to-peripheral bridge: window decode, one-hot device select/ack handshake, registered response.
// Optional access timeout is enabled by defining BRIDGE_TIMEOUT_EN.
module bus_bridge_hs #(
    parameter int                    N_DEV    = 3,
    parameter logic [N_DEV*32-1:0]   DEV_BASE = {32'h7F20, 32'h7F10, 32'h7F00},
    parameter logic [N_DEV*32-1:0]   DEV_MASK = {3{32'hFFFF_FFF0}},
    parameter int                    DEV_AW   = 3,
    parameter int                    TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PrReq,
    input  logic [31:0]           PrAddr,
    input  logic [31:0]           PrWD,
    input  logic                  PrWE,
    output logic [31:0]           PrRD,
    output logic                  PrReady,
    output logic                  PrErr,
    output logic [DEV_AW-1:0]     DEV_Addr,
    output logic [31:0]           DEV_WD,
    output logic [N_DEV-1:0]      DEV_SEL,
    output logic [N_DEV-1:0]      DEV_WE,
    input  logic [N_DEV*32-1:0]   DEV_RD,
    input  logic [N_DEV-1:0]      DEV_ACK
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [31:0]         prRd_q;
    logic                prReady_q;
    logic                prErr_q;
    logic [DEV_AW-1:0]   devAddr_q;
    logic [31:0]         devWd_q;
    logic [N_DEV-1:0]    devSel_q;
    logic [N_DEV-1:0]    devWe_q;

    logic [N_DEV-1:0]    hitVec;
    logic [N_DEV-1:0]    selOneHot;
    logic                found;
    logic [31:0]         rdSel;
    logic                ackHit;
    logic                timeoutHit;

    // Lowest-index window wins when several overlap.
    always_comb begin
        hitVec    = '0;
        selOneHot = '0;
        found     = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            hitVec[i] = ((PrAddr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]);
            if (hitVec[i] && !found) begin
                selOneHot[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Read data and ack are qualified by the registered one-hot select, so stray acks are ignored.
    always_comb begin
        rdSel = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (devSel_q[i]) begin
                rdSel = rdSel | DEV_RD[32*i +: 32];
            end
        end
        ackHit = |(DEV_ACK & devSel_q);
    end

`ifdef BRIDGE_TIMEOUT_EN
    logic [7:0] cnt_q;
    assign timeoutHit = (cnt_q == 8'(TIMEOUT - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prRd_q    <= '0;
            prReady_q <= 1'b0;
            prErr_q   <= 1'b0;
            devAddr_q <= '0;
            devWd_q   <= '0;
            devSel_q  <= '0;
            devWe_q   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (PrReq) begin
                        devAddr_q <= PrAddr[DEV_AW+1:2];
                        devWd_q   <= PrWD;
                        if (found) begin
                            devSel_q <= selOneHot;
                            devWe_q  <= PrWE ? selOneHot : '0;
                            state_q  <= ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
                            cnt_q    <= '0;
`endif
                        end else begin
                            prRd_q    <= '0;
                            prErr_q   <= 1'b1;
                            prReady_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (ackHit) begin
                        prRd_q    <= (|devWe_q) ? 32'h0 : rdSel;
                        prErr_q   <= 1'b0;
                        prReady_q <= 1'b1;
                        devSel_q  <= '0;
                        devWe_q   <= '0;
                        state_q   <= RESP;
                    end else if (timeoutHit) begin
                        prRd_q    <= '0;
                        prErr_q   <= 1'b1;
                        prReady_q <= 1'b1;
                        devSel_q  <= '0;
                        devWe_q   <= '0;
                        state_q   <= RESP;
                    end else begin
`ifdef BRIDGE_TIMEOUT_EN
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                RESP: begin
                    prReady_q <= 1'b0;
                    prErr_q   <= 1'b0;
                    prRd_q    <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PrRD     = prRd_q;
    assign PrReady  = prReady_q;
    assign PrErr    = prErr_q;
    assign DEV_Addr = devAddr_q;
    assign DEV_WD   = devWd_q;
    assign DEV_SEL  = devSel_q;
    assign DEV_WE   = devWe_q;

endmodule
